// File: rtl/serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_pkg : shared state encoding, nibble width, index-width helper
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_addsub_addersubtractor.sv
// ---------------------------------------------------------------------------
// addersubtractor : 4-bit combinational adder/subtractor slice (S = A + (B^Cin) + Cin)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module addersubtractor
   import serial_addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout,
   output logic                v
);

   logic [NIBBLE_W-1:0] bx;
   logic [NIBBLE_W:0]   sum;

   assign bx   = b ^ {NIBBLE_W{cin}};
   assign sum  = {1'b0, a} + {1'b0, bx} + {{NIBBLE_W{1'b0}}, cin};
   assign s    = sum[NIBBLE_W-1:0];
   assign cout = sum[NIBBLE_W];
   // Overflow: carry into the MSB differs from carry out of it.
   assign v    = cout ^ (a[NIBBLE_W-1] ^ bx[NIBBLE_W-1] ^ sum[NIBBLE_W-1]);

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub : multi-nibble serial adder/subtractor around one 4-bit slice.
// Optional zero/negative flags with SERIAL_ADDSUB_FLAGS_EN.   Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int NIBBLES = 4
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NIBBLES*NIBBLE_W-1:0]  in_a,
   input  logic [NIBBLES*NIBBLE_W-1:0]  in_b,
   input  logic                         in_sub,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NIBBLES*NIBBLE_W-1:0]  out_s,
   output logic                         out_c,
   output logic                         out_v
`ifdef SERIAL_ADDSUB_FLAGS_EN
   ,
   output logic                         out_z,
   output logic                         out_n
`endif
);

   localparam int W  = NIBBLES * NIBBLE_W;
   localparam int KW = (clog2(NIBBLES) > 0) ? clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] LAST_K = KW'(NIBBLES - 1);

   state_t              state;
   state_t              state_nx;
   logic [W-1:0]        a_sh;
   logic [W-1:0]        b_sh;
   logic [W-1:0]        res_nx;
   logic [KW-1:0]       k;
   logic                carry;
   logic                sub;
   logic                last;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_s;
   logic                slice_cout;
   logic                slice_v;

   assign last = (k == LAST_K);
   // Pre-inverting by carry cancels the slice's own B^Cin, so it always sees B or ~B.
   assign slice_b = b_sh[NIBBLE_W-1:0] ^ {NIBBLE_W{sub}} ^ {NIBBLE_W{carry}};

   addersubtractor u_slice (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (slice_b),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout),
      .v    (slice_v)
   );

   generate
      if (NIBBLES == 1) begin : g_single
         assign res_nx = slice_s;
      end else begin : g_multi
         // Lower result nibbles enter at the top and shift down, so the
         // final nibble lands the full word in LSB-first order.
         logic [W-NIBBLE_W-1:0] hold;

         always_ff @(posedge clk) begin
            if (rst) begin
               hold <= '0;
            end else if (state == RUN) begin
               hold <= res_nx[W-1:NIBBLE_W];
            end
         end

         assign res_nx = {slice_s, hold};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         k     <= '0;
         carry <= 1'b0;
         sub   <= 1'b0;
         out_s <= '0;
         out_c <= 1'b0;
         out_v <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
         out_z <= 1'b0;
         out_n <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= in_a;
                  b_sh  <= in_b;
                  sub   <= in_sub;
                  carry <= in_sub;
                  k     <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> NIBBLE_W;
               b_sh  <= b_sh >> NIBBLE_W;
               carry <= slice_cout;
               k     <= k + 1'b1;
               if (last) begin
                  out_s <= res_nx;
                  out_c <= slice_cout;
                  out_v <= slice_v;
`ifdef SERIAL_ADDSUB_FLAGS_EN
                  out_z <= (res_nx == '0);
                  out_n <= res_nx[W-1];
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub : randomized scoreboard bench for serial_addsub (NIBBLES=4)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_addsub;

   localparam int NIB = 4;
   localparam int W   = 16;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
      logic         z;
      logic         n;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_s;
   logic         out_c;
   logic         out_v;
`ifdef SERIAL_ADDSUB_FLAGS_EN
   logic         out_z;
   logic         out_n;
`endif

   exp_t sb[$];
   int   lat_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   rdy_mode = 0;
   logic prev_valid = 1'b0;
   exp_t mon_e;
   int   mon_t;

   serial_addsub #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_c     (out_c),
      .out_v     (out_v)
`ifdef SERIAL_ADDSUB_FLAGS_EN
      ,
      .out_z     (out_z),
      .out_n     (out_n)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: integer arithmetic on the whole word.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t       e;
      int         sa;
      int         sbv;
      int         r;
      logic [W:0] full;
      sa  = $signed(a);
      sbv = $signed(b);
      r   = sub ? (sa - sbv) : (sa + sbv);
      full = sub ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
      e.s = full[W-1:0];
      e.c = full[W];
      e.v = (r > 32767) || (r < -32768);
      e.z = (e.s == '0);
      e.n = e.s[W-1];
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Monitor: compares DUT results against the scoreboard.
   always begin
      @(negedge clk);
      #1;
      if (out_valid && !prev_valid) begin
         if (lat_q.size() != 0) begin
            mon_t = lat_q.pop_front();
            chk("latency", 32'(cyc - mon_t), 32'(NIB + 1));
         end
      end
      if (out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got out_s=0x%0h with no request pending", out_s);
         end else begin
            mon_e = out_ready ? sb.pop_front() : sb[0];
            chk("out_s", 32'(out_s), 32'(mon_e.s));
            chk("out_c", 32'(out_c), 32'(mon_e.c));
            chk("out_v", 32'(out_v), 32'(mon_e.v));
`ifdef SERIAL_ADDSUB_FLAGS_EN
            chk("out_z", 32'(out_z), 32'(mon_e.z));
            chk("out_n", 32'(out_n), 32'(mon_e.n));
`endif
            chk("in_ready_done", 32'(in_ready), 32'd0);
         end
      end
      prev_valid = out_valid;
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int t;
      t = 0;
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_sub   = s;
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
         in_valid = 1'b0;
      end else begin
         sb.push_back(model(a, b, s));
         lat_q.push_back(cyc);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         #2;
         t++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
         sb.delete();
         lat_q.delete();
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_s"},     32'(out_s),     32'd0);
      chk({tag, "_out_c"},     32'(out_c),     32'd0);
      chk({tag, "_out_v"},     32'(out_v),     32'd0);
`ifdef SERIAL_ADDSUB_FLAGS_EN
      chk({tag, "_out_z"},     32'(out_z),     32'd0);
      chk({tag, "_out_n"},     32'(out_n),     32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_sub   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle_zero("reset");

      send(16'h1234, 16'h0FCD, 1'b0);
      send(16'h7FFF, 16'h0001, 1'b0);
      send(16'h0000, 16'h0001, 1'b1);
      send(16'h8000, 16'h0001, 1'b1);
      send(16'h1234, 16'h1234, 1'b1);
      drain();

      // Backpressure with ignored requests while DONE.
      rdy_mode = 2;
      send(16'hABCD, 16'h1111, 1'b0);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         #2;
         t++;
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_a     = 16'($urandom);
         in_b     = 16'($urandom);
         in_sub   = 1'($urandom_range(0, 1));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rdy_mode = 0;
      drain();
      @(posedge clk);
      #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_out_valid", 32'(out_valid), 32'd0);
      send(16'h0001, 16'h0002, 1'b0);
      drain();

      // Reset in the second RUN cycle discards the operation.
      send(16'h5555, 16'h1111, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      lat_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero("midrun_reset");
      send(16'h0001, 16'h0001, 1'b0);
      drain();

      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         send(pick(), pick(), 1'($urandom_range(0, 1)));
      end
      drain();
      rdy_mode = 0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
